// File: rtl/inpass_pipe_config_pkg.sv
// Shared configuration layout for the input-pass pipeline: depth field sizing,
// config-bit offsets and the stage limit. The BelMap for ConfigBits uses these offsets.
package inpass_pipe_config_pkg;

  localparam int MAX_DEPTH_LIMIT  = 15;
  localparam int DEPTH_FIELD_BASE = 0;

  function automatic int depthBitsFor(input int maxDepth);
    return $clog2(maxDepth + 1);
  endfunction

  function automatic int depthFieldOffset(input int ch, input int depthBits);
    return DEPTH_FIELD_BASE + ch * depthBits;
  endfunction

  function automatic int ceEnIndex(input int width, input int depthBits);
    return DEPTH_FIELD_BASE + width * depthBits;
  endfunction

  function automatic logic my_mux2(input logic sel, input logic a0, input logic a1);
    return sel ? a1 : a0;
  endfunction

endpackage

// File: rtl/inpass_pipe_config_delay_line.sv
// One-bit delay line with MAX_DEPTH reset taps and a clamped combinational tap select.
module inpass_delay_line
  import inpass_pipe_config_pkg::*;
#(
  parameter int MAX_DEPTH  = 3,
  parameter int DEPTH_BITS = 2
) (
  input  logic                  UserCLK,
  input  logic                  UserRST,
  input  logic                  advance,
  input  logic                  din,
  input  logic [DEPTH_BITS-1:0] depth,
  output logic                  dout
);

  localparam int Stages = (MAX_DEPTH > MAX_DEPTH_LIMIT) ? MAX_DEPTH_LIMIT :
                          (MAX_DEPTH < 1) ? 1 : MAX_DEPTH;
  localparam logic [DEPTH_BITS-1:0] MaxCode = DEPTH_BITS'(Stages);

  logic [Stages:1]       taps;
  logic [DEPTH_BITS-1:0] tapSel;

  // Every tap shifts on each advance regardless of the selected depth,
  // so a depth change exposes history that is already captured.
  always_ff @(posedge UserCLK) begin
    if (UserRST) begin
      taps <= '0;
    end else if (advance) begin
      taps[1] <= din;
      for (int k = 2; k <= Stages; k++) begin
        taps[k] <= taps[k-1];
      end
    end
  end

  assign tapSel = (depth > MaxCode) ? MaxCode : depth;

  generate
    if (Stages == 1) begin : g_mux2
      assign dout = my_mux2(tapSel != '0, din, taps[1]);
    end else begin : g_muxn
      always_comb begin
        dout = din;
        for (int k = 1; k <= Stages; k++) begin
          if (tapSel == DEPTH_BITS'(k)) dout = taps[k];
        end
      end
    end
  endgenerate

endmodule

// File: rtl/inpass_pipe_config.sv
// Configurable input-pass block: WIDTH independent channels, each delayed by
// 0..MAX_DEPTH register stages selected from static ConfigBits, with optional CE gating.
module inpass_pipe_config
  import inpass_pipe_config_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int MAX_DEPTH    = 3,
  parameter int DEPTH_BITS   = depthBitsFor(MAX_DEPTH),
  parameter int NoConfigBits = WIDTH * DEPTH_BITS + 1
) (
  input  logic                    UserCLK,
  input  logic                    UserRST,
  input  logic [WIDTH-1:0]        I,
  input  logic                    CE,
  output logic [WIDTH-1:0]        O,
  input  logic [NoConfigBits-1:0] ConfigBits
);

  localparam int CeEnIdx = ceEnIndex(WIDTH, DEPTH_BITS);

  logic ceEn;
  logic advance;

  assign ceEn    = ConfigBits[CeEnIdx];
  assign advance = !UserRST && (!ceEn || CE);

  generate
    for (genvar c = 0; c < WIDTH; c++) begin : g_ch
      inpass_delay_line #(
        .MAX_DEPTH (MAX_DEPTH),
        .DEPTH_BITS(DEPTH_BITS)
      ) u_line (
        .UserCLK(UserCLK),
        .UserRST(UserRST),
        .advance(advance),
        .din    (I[c]),
        .depth  (ConfigBits[depthFieldOffset(c, DEPTH_BITS) +: DEPTH_BITS]),
        .dout   (O[c])
      );
    end
  endgenerate

endmodule

// File: tb/tb_inpass_pipe_config.sv
// Bench for inpass_pipe_config: directed scenarios on default and clamp configurations,
// plus a long randomized run on an 8-channel, 7-deep instance against a history model.
module tb_inpass_pipe_config;

  typedef logic [7:0] hist_t [16];

  logic UserCLK = 1'b0;
  always #5 UserCLK = ~UserCLK;

  int nChecks = 0;
  int nFails  = 0;

  // Instance A: defaults
  logic       rstA, ceA;
  logic [3:0] iA, oA;
  logic [8:0] cfgA;
  inpass_pipe_config dutA (
    .UserCLK(UserCLK), .UserRST(rstA), .I(iA), .CE(ceA), .O(oA), .ConfigBits(cfgA)
  );

  // Instance B: wide and deep, randomized
  logic        rstB, ceB;
  logic [7:0]  iB, oB;
  logic [24:0] cfgB;
  inpass_pipe_config #(.WIDTH(8), .MAX_DEPTH(7), .DEPTH_BITS(3)) dutB (
    .UserCLK(UserCLK), .UserRST(rstB), .I(iB), .CE(ceB), .O(oB), .ConfigBits(cfgB)
  );

  // Instance C: depth code above MAX_DEPTH
  logic       rstC, ceC;
  logic [1:0] iC, oC;
  logic [4:0] cfgC;
  inpass_pipe_config #(.WIDTH(2), .MAX_DEPTH(2), .DEPTH_BITS(2)) dutC (
    .UserCLK(UserCLK), .UserRST(rstC), .I(iC), .CE(ceC), .O(oC), .ConfigBits(cfgC)
  );

  // hist[k] is the input sampled k+1 advance cycles ago (zeros after reset)
  hist_t histA, histB, histC;

  function automatic hist_t stepHist(hist_t h, logic rst, logic adv, logic [7:0] i);
    hist_t n;
    if (rst) begin
      for (int k = 0; k < 16; k++) n[k] = '0;
    end else if (adv) begin
      n[0] = i;
      for (int k = 1; k < 16; k++) n[k] = h[k-1];
    end else begin
      n = h;
    end
    return n;
  endfunction

  function automatic logic [7:0] modelOut(hist_t h, logic [7:0] i, logic [31:0] cfg,
                                          int w, int db, int maxD);
    logic [7:0] r;
    int d;
    r = '0;
    for (int c = 0; c < w; c++) begin
      d = int'((cfg >> (c * db)) & ((32'd1 << db) - 32'd1));
      if (d > maxD) d = maxD;
      r[c] = (d == 0) ? i[c] : h[d-1][c];
    end
    return r;
  endfunction

  task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge UserCLK);
    histA = stepHist(histA, rstA, !cfgA[8] || ceA, {4'b0, iA});
    histB = stepHist(histB, rstB, !cfgB[24] || ceB, iB);
    histC = stepHist(histC, rstC, !cfgC[4] || ceC, {6'b0, iC});
    #1;
  endtask

  task automatic checkA(string tag);
    @(negedge UserCLK);
    check(tag, {4'b0, oA}, modelOut(histA, {4'b0, iA}, {23'b0, cfgA}, 4, 2, 3));
  endtask

  task automatic checkB(string tag);
    @(negedge UserCLK);
    check(tag, oB, modelOut(histB, iB, {7'b0, cfgB}, 8, 3, 7));
  endtask

  task automatic checkC(string tag);
    @(negedge UserCLK);
    check(tag, {6'b0, oC}, modelOut(histC, {6'b0, iC}, {27'b0, cfgC}, 2, 2, 2));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0] cePat;
    logic [4:0] iPat;
    logic [3:0] strm;
    logic       b;

    for (int k = 0; k < 16; k++) begin
      histA[k] = '0; histB[k] = '0; histC[k] = '0;
    end
    rstA = 1'b1; ceA = 1'b0; iA = '0; cfgA = 9'b0_11_10_01_00;
    rstB = 1'b1; ceB = 1'b0; iB = '0; cfgB = '0;
    rstC = 1'b1; ceC = 1'b0; iC = '0; cfgC = 5'b0_10_11;
    tick(); tick();
    rstA = 1'b0;

    // Depths 0/1/2/3 on ch0..3, CE ignored, toggling input
    @(negedge UserCLK);
    check("reset_state", {4'b0, oA}, 8'h00);
    for (int n = 0; n < 8; n++) begin
      iA = n[0] ? 4'hF : 4'h0;
      ceA = $urandom_range(0, 1);
      checkA("toggle_depths");
      if (n < 3) check("toggle_ch3_zero", {7'b0, oA[3]}, 8'h00);
      tick();
    end

    // CE gating with all depths 2
    rstA = 1'b1; cfgA = 9'b1_10_10_10_10; tick(); rstA = 1'b0;
    cePat = 5'b11001;
    iPat  = 5'b10101;
    for (int s = 0; s < 5; s++) begin
      ceA = cePat[s];
      iA  = iPat[s] ? 4'hF : 4'h0;
      checkA("ce_pattern");
      tick();
    end
    ceA = 1'b0;
    for (int s = 0; s < 3; s++) begin
      iA = 4'($urandom);
      checkA("ce_hold");
      check("ce_hold_value", {4'b0, oA}, 8'h00);
      tick();
    end

    // Depth change exposes captured history without a bubble
    rstA = 1'b1; cfgA = 9'b0_00_00_00_11; tick(); rstA = 1'b0;
    strm = 4'b1011;
    for (int s = 0; s < 4; s++) begin
      iA = {3'b000, strm[s]};
      checkA("stream_d3");
      tick();
    end
    iA = 4'h0;
    cfgA = 9'b0_00_00_00_01;
    checkA("depth_change");
    check("depth_change_newest", {7'b0, oA[0]}, 8'h01);
    tick();

    // Mid-stream reset pulse
    cfgA = 9'b0_10_01_00_11;
    for (int s = 0; s < 5; s++) begin
      iA = 4'($urandom);
      checkA("pre_reset");
      tick();
    end
    rstA = 1'b1;
    iA = 4'($urandom);
    checkA("in_reset");
    tick();
    rstA = 1'b0;
    for (int s = 0; s < 6; s++) begin
      iA = 4'($urandom);
      checkA("post_reset");
      if (s < 3) check("post_reset_ch0_zero", {7'b0, oA[0]}, 8'h00);
      tick();
    end

    // Clamp: code 3 on a 2-deep line behaves like depth 2
    rstC = 1'b0;
    for (int s = 0; s < 10; s++) begin
      b = 1'($urandom);
      iC = {b, b};
      ceC = $urandom_range(0, 1);
      cfgC[4] = 1'($urandom);
      checkC("clamp_model");
      check("clamp_equal", {7'b0, oC[0]}, {7'b0, oC[1]});
      tick();
    end

    // Randomized wide/deep run with random reset injection
    rstB = 1'b0;
    for (int n = 0; n < 10000; n++) begin
      if (n % 50 == 0) cfgB = 25'($urandom);
      rstB = ($urandom_range(0, 63) == 0);
      ceB  = 1'($urandom);
      iB   = 8'($urandom);
      checkB("random");
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/inpass_pipe_config.md
INPASS_PIPE_CONFIG -- requirements
Module: inpass_pipe_config

Interface
REQ-001 Parameter WIDTH, default 4: number of independent input-pass channels.
REQ-002 Parameter MAX_DEPTH, default 3: maximum register stages per channel; legal range 1..15.
REQ-003 Parameter DEPTH_BITS, default 2: per-channel depth field width, equal to ceil(log2(MAX_DEPTH+1)).
REQ-004 Parameter NoConfigBits, default WIDTH*DEPTH_BITS+1 (9 at defaults): total configuration bits.
REQ-005 UserCLK  input  1: single clock, rising edge; EXTERNAL, SHARED_PORT.
REQ-006 UserRST  input  1: reset, synchronous and active-high; EXTERNAL, SHARED_PORT.
REQ-007 I  input  WIDTH: fabric-side data in, one bit per channel; EXTERNAL.
REQ-008 CE  input  1: shared clock enable from fabric; EXTERNAL.
REQ-009 O  output  WIDTH: data out, one bit per channel.
REQ-010 ConfigBits  input  NoConfigBits: GLOBAL, static frame configuration; listed last.

Function
REQ-011 Config layout: ConfigBits[c*DEPTH_BITS +: DEPTH_BITS] = DEPTH[c]; ConfigBits[WIDTH*DEPTH_BITS] = CE_EN.
REQ-012 Each channel c: shift register S[c][1..MAX_DEPTH]; on an advance cycle S[c][1] <= I[c], S[c][k] <= S[c][k-1].
REQ-013 Advance cycle: UserRST=0 and (CE_EN=0 or CE=1); otherwise every S holds.
REQ-014 O[c] = I[c] combinationally when DEPTH[c]=0; O[c] = S[c][DEPTH[c]] when 1 <= DEPTH[c] <= MAX_DEPTH.
REQ-015 DEPTH[c] > MAX_DEPTH clamps to MAX_DEPTH.
REQ-016 Latency: DEPTH[c]=d>0 gives O[c] equal to I[c] sampled d advance cycles earlier; with CE_EN=0, exactly d UserCLK cycles.
REQ-017 All stages shift on every advance cycle regardless of DEPTH[c], so a depth change exposes already-captured history with no flush or bubble.
REQ-018 Depth change takes effect on O in the same cycle (combinational tap select), with no glitch-free guarantee.
REQ-019 CE_EN=0 ignores CE; CE_EN=1 with CE held low freezes all taps indefinitely.
REQ-020 Channels are fully independent; there is no cross-channel coupling except the shared CE/UserRST.
REQ-021 No X propagation: every tap is a reset register; the output mux covers all DEPTH codes.

Reset
REQ-022 UserRST=1 at a rising edge clears every S[c][k] to 0; reset has priority over CE.
REQ-023 During and after reset, O[c]=0 for DEPTH[c]>0 until d advance cycles have elapsed; O[c] follows I[c] for DEPTH[c]=0 even while UserRST=1.
REQ-024 Reset asserted mid-stream discards all in-flight data; no partial state survives.

Structure
REQ-025 Shared package holds DEPTH_BITS derivation, config field offsets (depth field base, CE_EN index) and MAX_DEPTH limit; the BelMap for the config bits is generated from the same offsets.
REQ-026 One sub-module, inpass_delay_line (1-bit, MAX_DEPTH stages, clamped tap select), instantiated WIDTH times via generate; per-bit output selection uses my_mux2 where the tap count is 2.
REQ-027 No latches, no derived clocks; all flops on UserCLK.

Verification
REQ-028 Defaults, DEPTH=0,1,2,3 on ch0..3, CE_EN=0, I toggles 0000/1111 each cycle after reset -> O[0] same-cycle, O[1..3] reproduce the pattern delayed 1/2/3 cycles, O[1..3]=0 for the first 1/2/3 cycles.
REQ-029 CE_EN=1, all DEPTH=2, CE pattern 1,0,0,1,1 with I=1,0,1,0,1 -> only samples on CE=1 cycles (1,0,1) propagate; O holds during CE=0.
REQ-030 Stream 1,1,0,1 into ch0 at DEPTH=3, change DEPTH to 1 after the 4th edge -> O[0] immediately equals the newest sample (1), no zero bubble.
REQ-031 UserRST pulsed one cycle mid-stream, DEPTH=3 -> O=0 for 3 cycles after release, then the post-reset data; DEPTH=0 channel tracks I throughout.
REQ-032 MAX_DEPTH=2, DEPTH_BITS=2, DEPTH code 3 -> behaves identically to DEPTH=2 (clamp).
REQ-033 WIDTH=8, MAX_DEPTH=7 random I/CE/config -> O matches a cycle-accurate reference model over 10k cycles with reset injected randomly.
